// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - data-side bus target: word RAM, MMIO timer and TX byte FIFO
// Optional timer block enabled by defining BUS_RESPONDER_TIMER_EN.
module bus_responder #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    input  logic        bus_write,
    input  logic        bus_read,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    logic           ram_hit, mmio_hit, unmapped;
    logic [AW-1:0]  ram_idx;
    logic [1:0]     mmio_off;
    logic           wr_status, wr_tx;
    logic [31:0]    count_rd, cmp_rd;
    logic           match_rd;

    logic [31:0]    ram_mem [RAM_WORDS];
    logic [7:0]     fifo_mem [FIFO_DEPTH];

    logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic           err_q, err_d, ovf_q, ovf_d;
    logic           fifo_full, fifo_empty, push, pop;
    logic [31:0]    status;

    always_comb begin
        ram_hit   = {1'b0, bus_address} < RAM_BYTES;
        mmio_hit  = bus_address[31:4] == MMIO_BASE[31:4];
        unmapped  = !ram_hit && !mmio_hit;
        ram_idx   = bus_address[AW+1:2];
        mmio_off  = bus_address[3:2];
        wr_status = bus_write && mmio_hit && (mmio_off == 2'd2);
        wr_tx     = bus_write && mmio_hit && (mmio_off == 2'd3);
    end

`ifdef BUS_RESPONDER_TIMER_EN
    logic [31:0] count_q, count_d, cmp_q, cmp_d;
    logic        match_q, match_d;
    logic        wr_count, wr_cmp;

    always_comb begin
        wr_count = bus_write && mmio_hit && (mmio_off == 2'd0);
        wr_cmp   = bus_write && mmio_hit && (mmio_off == 2'd1);
        count_d  = wr_count ? bus_write_data : count_q + 32'd1;
        cmp_d    = wr_cmp ? bus_write_data : cmp_q;
        match_d  = match_q;
        if (wr_status && bus_write_data[0])
            match_d = 1'b0;
        // A new match outranks a software clear in the same cycle.
        if (count_q == cmp_q)
            match_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 32'd0;
            cmp_q   <= 32'hFFFF_FFFF;
            match_q <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
        end
    end

    assign count_rd = count_q;
    assign cmp_rd   = cmp_q;
    assign match_rd = match_q;
`else
    assign count_rd = 32'd0;
    assign cmp_rd   = 32'd0;
    assign match_rd = 1'b0;
`endif

    assign timer_irq = match_rd;

    always_comb begin
        fifo_empty = fifo_cnt_q == '0;
        fifo_full  = fifo_cnt_q == CW'(FIFO_DEPTH);
        pop        = !fifo_empty && tx_ready;
        // A full FIFO still takes a byte when the head leaves in the same cycle.
        push       = wr_tx && (!fifo_full || pop);
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop)
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        else if (pop && !push)
            fifo_cnt_d = fifo_cnt_q - CW'(1);

        err_d = err_q;
        ovf_d = ovf_q;
        if (wr_status && bus_write_data[3])
            err_d = 1'b0;
        if (wr_status && bus_write_data[4])
            ovf_d = 1'b0;
        if ((bus_read || bus_write) && unmapped)
            err_d = 1'b1;
        if (wr_tx && !push)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage arrays carry no reset; writes are still blocked during reset.
    always_ff @(posedge clock) begin
        if (!reset && bus_write && ram_hit)
            ram_mem[ram_idx] <= bus_write_data;
        if (!reset && push)
            fifo_mem[wr_ptr_q] <= bus_write_data[7:0];
    end

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_mem[rd_ptr_q];

    always_comb begin
        status        = {16'd0, 8'(fifo_cnt_q), 3'd0, ovf_q, err_q,
                         fifo_empty, fifo_full, match_rd};
        bus_read_data = 32'd0;
        if (bus_read) begin
            if (ram_hit) begin
                bus_read_data = ram_mem[ram_idx];
            end else if (mmio_hit) begin
                case (mmio_off)
                    2'd0:    bus_read_data = count_rd;
                    2'd1:    bus_read_data = cmp_rd;
                    2'd2:    bus_read_data = status;
                    default: bus_read_data = 32'd0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - directed self-checking bench for bus_responder
// Follows BUS_RESPONDER_TIMER_EN to pick timer expectations.
module tb_bus_responder;
    localparam logic [31:0] A_COUNT  = 32'h8000_0000;
    localparam logic [31:0] A_CMP    = 32'h8000_0004;
    localparam logic [31:0] A_STATUS = 32'h8000_0008;
    localparam logic [31:0] A_TX     = 32'h8000_000C;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bus_address = '0;
    logic [31:0] bus_write_data = '0;
    logic [31:0] bus_read_data;
    logic        bus_write = 1'b0;
    logic        bus_read = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        timer_irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;

    bus_responder dut (
        .clock          (clock),
        .reset          (reset),
        .bus_address    (bus_address),
        .bus_write_data (bus_write_data),
        .bus_read_data  (bus_read_data),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .timer_irq      (timer_irq)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        bus_address    = addr;
        bus_write_data = data;
        bus_write      = 1'b1;
        tick();
        bus_write      = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        bus_address = addr;
        bus_read    = 1'b1;
        #1;
        data        = bus_read_data;
        bus_read    = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;

        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_irq", 32'(timer_irq), 32'd0);
        do_read(A_STATUS, rd); check("rst_status", rd, 32'h4);
        do_read(A_COUNT, rd);  check("rst_count", rd, 32'h0);
`ifdef BUS_RESPONDER_TIMER_EN
        do_read(A_CMP, rd);    check("rst_cmp", rd, 32'hFFFF_FFFF);
`else
        do_read(A_CMP, rd);    check("rst_cmp", rd, 32'h0);
`endif
        check("idle_read_zero", bus_read_data, 32'h0);

        // RAM word access and sub-word address aliasing
        do_write(32'h14, 32'h1234_5678);
        do_write(32'h10, 32'hDEAD_BEEF);
        do_read(32'h10, rd); check("ram_10", rd, 32'hDEAD_BEEF);
        do_read(32'h12, rd); check("ram_12", rd, 32'hDEAD_BEEF);
        do_read(32'h14, rd); check("ram_14", rd, 32'h1234_5678);

        // Read-during-write shows the old word
        bus_address = 32'h14; bus_write_data = 32'hA5A5_0001;
        bus_write = 1'b1; bus_read = 1'b1; #1;
        check("rdw_old", bus_read_data, 32'h1234_5678);
        tick(); bus_write = 1'b0; bus_read = 1'b0;
        do_read(32'h14, rd); check("rdw_new", rd, 32'hA5A5_0001);

        // Unmapped access
        bus_address = 32'h4000_0000; bus_read = 1'b1; #1;
        check("unmapped_rd", bus_read_data, 32'h0);
        tick(); bus_read = 1'b0;
        do_write(32'h4000_0000, 32'h1111_1111);
        do_read(A_STATUS, rd); check("bus_err_set", rd, 32'hC);
        do_write(A_STATUS, 32'h8);
        do_read(A_STATUS, rd); check("bus_err_clr", rd, 32'h4);

`ifdef BUS_RESPONDER_TIMER_EN
        do_write(A_CMP, 32'h0);
        do_write(A_COUNT, 32'hFFFF_FFFE);
        do_read(A_COUNT, rd); check("cnt_fffe", rd, 32'hFFFF_FFFE);
        tick(); do_read(A_COUNT, rd); check("cnt_ffff", rd, 32'hFFFF_FFFF);
        tick(); do_read(A_COUNT, rd); check("cnt_0", rd, 32'h0);
        check("irq_pre", 32'(timer_irq), 32'd0);
        do_write(A_STATUS, 32'h1);
        do_read(A_COUNT, rd); check("cnt_1", rd, 32'h1);
        check("irq_set_wins", 32'(timer_irq), 32'd1);
        do_read(A_STATUS, rd); check("match_set", rd, 32'h5);
        do_write(A_STATUS, 32'h1);
        check("irq_cleared", 32'(timer_irq), 32'd0);
`else
        do_write(A_COUNT, 32'h1234);
        do_write(A_CMP, 32'h0);
        do_read(A_COUNT, rd); check("cnt_absent", rd, 32'h0);
        do_read(A_CMP, rd);   check("cmp_absent", rd, 32'h0);
        do_read(A_STATUS, rd); check("no_err_timer", rd, 32'h4);
        tick(); tick();
        check("irq_tied", 32'(timer_irq), 32'd0);
`endif

        // Fill past capacity with consumer stalled
        for (int i = 0; i < 5; i++) do_write(A_TX, 32'h41 + i);
        do_read(A_STATUS, rd); check("fifo_full_ovf", rd, 32'h0412);
        check("head_41", 32'(tx_data), 32'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid%0d", i), 32'(tx_valid), 32'd1);
            check($sformatf("drain_data%0d", i), 32'(tx_data), 32'h41 + i);
            tick();
        end
        check("drained_valid", 32'(tx_valid), 32'd0);
        do_read(A_STATUS, rd); check("drained_status", rd, 32'h14);
        do_write(A_STATUS, 32'h10);
        do_read(A_STATUS, rd); check("ovf_clr", rd, 32'h4);

        // Push into a full FIFO while the head is popped
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_write(A_TX, 32'h51 + i);
        tx_ready = 1'b1;
        do_write(A_TX, 32'h55);
        do_read(A_STATUS, rd); check("full_push_pop", rd, 32'h0402);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_data%0d", i), 32'(tx_data), 32'h52 + i);
            tick();
        end
        check("pp_empty", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;

        // Reset mid-operation
        do_write(A_TX, 32'h61);
        do_write(A_TX, 32'h62);
        do_write(32'h20, 32'hCAFE_F00D);
        do_write(A_COUNT, 32'h1234);
        reset = 1'b1;
        bus_address = 32'h20; bus_write_data = 32'h0000_0BAD; bus_write = 1'b1;
        tick();
        reset = 1'b0; bus_write = 1'b0;
        check("mid_rst_valid", 32'(tx_valid), 32'd0);
        do_read(A_COUNT, rd);  check("mid_rst_count", rd, 32'h0);
`ifdef BUS_RESPONDER_TIMER_EN
        do_read(A_CMP, rd);    check("mid_rst_cmp", rd, 32'hFFFF_FFFF);
`else
        do_read(A_CMP, rd);    check("mid_rst_cmp", rd, 32'h0);
`endif
        do_read(A_STATUS, rd); check("mid_rst_status", rd, 32'h4);
        do_read(32'h20, rd);   check("ram_survives", rd, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
